// File: rtl/multi_cycle_mdu.sv
// multi_cycle_mdu
// Multi-cycle multiply/divide unit with HI/LO result registers, in the style of
// a classic MIPS HI/LO unit. Multiplies produce a full 2*DATA_W product after
// MUL_LAT busy cycles. Divides run a restoring divider, one quotient bit per
// cycle, for DATA_W busy cycles, leaving the quotient in LO and the remainder
// in HI.
//
// Optional feature: define MDU_MADD_EN to enable the accumulate operations
// MADD/MADDU/MSUB/MSUBU (codes 8-11). Without it those codes are reserved and
// ignored.
//
// Parameters:
//   DATA_W   operand and HI/LO width (8..64, even)
//   MUL_LAT  multiply busy cycles (1..16)
//
// Ports:
//   clock      single clock, rising edge
//   reset      synchronous, active-high
//   start      request strobe, sampled only while busy=0
//   flush      abort the in-flight operation (and drop a same-cycle request)
//   operation  4-bit operation code
//   operand1   rs: dividend, multiplicand or HI/LO write data
//   operand2   rt: divisor or multiplier
//   busy       long operation in flight
//   done       one-cycle pulse after HI/LO take a long-operation result
//   dataRead   HI when operation=READ_HI, otherwise LO (combinational)

module multi_cycle_mdu #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              flush,
    input  logic [3:0]        operation,
    input  logic [DATA_W-1:0] operand1,
    input  logic [DATA_W-1:0] operand2,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dataRead
);

    localparam int DIV_LAT = DATA_W;
    localparam int CNT_W   = 7;

    localparam logic [3:0] OP_READ_HI  = 4'd0;
    localparam logic [3:0] OP_WRITE_HI = 4'd2;
    localparam logic [3:0] OP_WRITE_LO = 4'd3;
    localparam logic [3:0] OP_MULT     = 4'd4;
    localparam logic [3:0] OP_MULTU    = 4'd5;
    localparam logic [3:0] OP_DIV      = 4'd6;
    localparam logic [3:0] OP_DIVU     = 4'd7;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD     = 4'd8;
    localparam logic [3:0] OP_MADDU    = 4'd9;
    localparam logic [3:0] OP_MSUB     = 4'd10;
    localparam logic [3:0] OP_MSUBU    = 4'd11;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                done_q, done_d;
    logic [3:0]          op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   quo_q, quo_d;
    logic [DATA_W-1:0]   rem_q, rem_d;

    // Every long operation code has its unsigned variant on the odd code,
    // so bit 0 of the latched operation selects unsigned arithmetic.
    logic op_signed;
    assign op_signed = ~op_q[0];

    // Full-width product from the latched operands, sign- or zero-extended
    // to 2*DATA_W so the truncated product is exact in both modes.
    logic [2*DATA_W-1:0] mul_a, mul_b, product, mul_result;

    always_comb begin
        mul_a   = op_signed ? {{DATA_W{a_q[DATA_W-1]}}, a_q} : {{DATA_W{1'b0}}, a_q};
        mul_b   = op_signed ? {{DATA_W{b_q[DATA_W-1]}}, b_q} : {{DATA_W{1'b0}}, b_q};
        product = mul_a * mul_b;
    end

    // Plain multiplies overwrite {HI,LO}; accumulate forms add or subtract
    // the product modulo 2^(2*DATA_W).
`ifdef MDU_MADD_EN
    always_comb begin
        case (op_q)
            OP_MADD, OP_MADDU: mul_result = {hi_q, lo_q} + product;
            OP_MSUB, OP_MSUBU: mul_result = {hi_q, lo_q} - product;
            default:           mul_result = product;
        endcase
    end
`else
    assign mul_result = product;
`endif

    // One restoring-divide step on magnitudes. quo_q starts as |dividend|
    // and shifts quotient bits in from the right as dividend bits leave on
    // the left. The remainder always fits DATA_W bits: when the shifted
    // value overflows DATA_W bits it is necessarily >= the divisor, so the
    // subtraction branch brings it back into range.
    logic [DATA_W-1:0] dvs_mag;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W:0]   dvs_ext;
    logic [DATA_W-1:0] rem_next, quo_next;
    logic [DATA_W-1:0] quo_final, rem_final;
    logic              quo_neg, rem_neg;

    always_comb begin
        dvs_mag   = (op_signed && b_q[DATA_W-1]) ? -b_q : b_q;
        div_shift = {rem_q, quo_q[DATA_W-1]};
        dvs_ext   = {1'b0, dvs_mag};
        if (div_shift >= dvs_ext) begin
            rem_next = DATA_W'(div_shift - dvs_ext);
            quo_next = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
            rem_next = div_shift[DATA_W-1:0];
            quo_next = {quo_q[DATA_W-2:0], 1'b0};
        end

        // Quotient truncates toward zero; remainder follows the dividend.
        // MIN / -1 falls out naturally: the magnitude quotient 2^(DATA_W-1)
        // is its own negation in DATA_W bits.
        quo_neg   = op_signed && (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
        rem_neg   = op_signed && a_q[DATA_W-1];
        quo_final = quo_neg ? -quo_next : quo_next;
        rem_final = rem_neg ? -rem_next : rem_next;

        // Divide by zero leaves the raw dividend in HI and all ones in LO.
        if (b_q == '0) begin
            quo_final = '1;
            rem_final = a_q;
        end
    end

    // Next-state logic: request decode in IDLE, countdown and completion in
    // MUL/DIV. flush beats any in-flight work and any same-cycle request.
    logic accept_mul, accept_div;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        accept_mul = 1'b0;
        accept_div = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    case (operation)
                        OP_WRITE_HI:       hi_d = operand1;
                        OP_WRITE_LO:       lo_d = operand1;
                        OP_MULT, OP_MULTU: accept_mul = 1'b1;
`ifdef MDU_MADD_EN
                        OP_MADD, OP_MADDU,
                        OP_MSUB, OP_MSUBU: accept_mul = 1'b1;
`endif
                        OP_DIV, OP_DIVU:   accept_div = 1'b1;
                        default:           ;
                    endcase
                end
                if (accept_mul || accept_div) begin
                    op_d = operation;
                    a_d  = operand1;
                    b_d  = operand2;
                end
                if (accept_mul) begin
                    count_d = CNT_W'(MUL_LAT);
                    state_d = ST_MUL;
                end
                if (accept_div) begin
                    count_d = CNT_W'(DIV_LAT);
                    quo_d   = (operation == OP_DIV && operand1[DATA_W-1]) ? -operand1 : operand1;
                    rem_d   = '0;
                    state_d = ST_DIV;
                end
            end

            ST_MUL: begin
                if (flush) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    count_d = count_q - 1'b1;
                    if (count_q == CNT_W'(1)) begin
                        {hi_d, lo_d} = mul_result;
                        done_d       = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
            end

            ST_DIV: begin
                if (flush) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    count_d = count_q - 1'b1;
                    quo_d   = quo_next;
                    rem_d   = rem_next;
                    if (count_q == CNT_W'(1)) begin
                        hi_d    = rem_final;
                        lo_d    = quo_final;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // All state lives here; reset clears results and abandons any operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign dataRead = (operation == OP_READ_HI) ? hi_q : lo_q;

endmodule

// File: tb/tb_multi_cycle_mdu.sv
// tb_multi_cycle_mdu
// Directed self-checking bench for multi_cycle_mdu at DATA_W=32, MUL_LAT=5.
// Inputs are driven and outputs sampled on the falling clock edge.
// Follows MDU_MADD_EN the same way the design does for the MSUB vector.

module tb_multi_cycle_mdu;

    localparam int W = 32;

    localparam logic [3:0] READ_HI  = 4'd0;
    localparam logic [3:0] READ_LO  = 4'd1;
    localparam logic [3:0] WRITE_HI = 4'd2;
    localparam logic [3:0] WRITE_LO = 4'd3;
    localparam logic [3:0] MULT     = 4'd4;
    localparam logic [3:0] MULTU    = 4'd5;
    localparam logic [3:0] DIV      = 4'd6;
    localparam logic [3:0] DIVU     = 4'd7;
    localparam logic [3:0] MSUB     = 4'd10;
    localparam logic [3:0] RESV     = 4'd12;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         flush;
    logic [3:0]   operation;
    logic [W-1:0] operand1;
    logic [W-1:0] operand2;
    logic         busy;
    logic         done;
    logic [W-1:0] dataRead;

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    multi_cycle_mdu #(.DATA_W(W), .MUL_LAT(5)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .flush     (flush),
        .operation (operation),
        .operand1  (operand1),
        .operand2  (operand2),
        .busy      (busy),
        .done      (done),
        .dataRead  (dataRead)
    );

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic readHiLo(output logic [W-1:0] hi, output logic [W-1:0] lo);
        operation = READ_HI;
        #1 hi = dataRead;
        operation = READ_LO;
        #1 lo = dataRead;
    endtask

    // One-cycle request; returns on the falling edge after the accepting edge,
    // with operands scrambled to show they were captured at acceptance.
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        start     = 1'b1;
        operation = op;
        operand1  = a;
        operand2  = b;
        @(negedge clock);
        start     = 1'b0;
        operation = READ_LO;
        operand1  = 32'hDEADBEEF;
        operand2  = 32'h0BADF00D;
    endtask

    // Counts remaining busy falling edges, bounded so a stuck DUT still ends.
    task automatic waitDone(output int cycles, output logic doneSeen);
        cycles = 0;
        while (busy === 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge clock);
        end
        doneSeen = done;
    endtask

    task automatic runCheck(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input int expCycles,
                            input logic [W-1:0] expHi, input logic [W-1:0] expLo);
        int cycles;
        logic doneSeen;
        logic [W-1:0] hi, lo;
        applyStimulus(op, a, b);
        waitDone(cycles, doneSeen);
        checkOutput({tag, " busy cycles"}, 64'(cycles), 64'(expCycles));
        checkOutput({tag, " done pulse"}, 64'(doneSeen), 64'd1);
        readHiLo(hi, lo);
        checkOutput({tag, " HI"}, 64'(hi), 64'(expHi));
        checkOutput({tag, " LO"}, 64'(lo), 64'(expLo));
        @(negedge clock);
        checkOutput({tag, " done falls"}, 64'(done), 64'd0);
    endtask

    task automatic writeReg(input logic [3:0] op, input logic [W-1:0] value);
        @(negedge clock);
        start     = 1'b1;
        operation = op;
        operand1  = value;
        @(negedge clock);
        start     = 1'b0;
        operation = READ_LO;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        logic doneSeen;
        logic [W-1:0] hi, lo;

        reset     = 1'b1;
        start     = 1'b0;
        flush     = 1'b0;
        operation = READ_LO;
        operand1  = '0;
        operand2  = '0;
        repeat (2) @(negedge clock);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        readHiLo(hi, lo);
        checkOutput("reset HI", 64'(hi), 64'd0);
        checkOutput("reset LO", 64'(lo), 64'd0);
        reset = 1'b0;

        // Arithmetic vectors with hand-computed results.
        runCheck("MULT -3x7",       MULT,  32'hFFFFFFFD, 32'd7,        5,  32'hFFFFFFFF, 32'hFFFFFFEB);
        runCheck("MULTU max*max",   MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001);
        runCheck("DIV -7/2",        DIV,   32'hFFFFFFF9, 32'd2,        32, 32'hFFFFFFFF, 32'hFFFFFFFD);
        runCheck("DIV 7/-2",        DIV,   32'd7,        32'hFFFFFFFE, 32, 32'h00000001, 32'hFFFFFFFD);
        runCheck("DIVU 100/7",      DIVU,  32'd100,      32'd7,        32, 32'h00000002, 32'h0000000E);
        runCheck("DIVU 7/0",        DIVU,  32'd7,        32'd0,        32, 32'h00000007, 32'hFFFFFFFF);
        runCheck("DIV -5/0",        DIV,   32'hFFFFFFFB, 32'd0,        32, 32'hFFFFFFFB, 32'hFFFFFFFF);
        runCheck("DIV min/-1",      DIV,   32'h80000000, 32'hFFFFFFFF, 32, 32'h00000000, 32'h80000000);

        // Writes take effect immediately and never raise busy or done.
        writeReg(WRITE_HI, 32'h00001234);
        checkOutput("write busy", 64'(busy), 64'd0);
        checkOutput("write done", 64'(done), 64'd0);
        writeReg(WRITE_LO, 32'h00005678);
        readHiLo(hi, lo);
        checkOutput("write HI", 64'(hi), 64'h1234);
        checkOutput("write LO", 64'(lo), 64'h5678);

        // Flush a divide at busy cycle 10.
        applyStimulus(DIVU, 32'd1000, 32'd3);
        cycles = 1;
        while (cycles < 10 && busy === 1'b1) begin
            @(negedge clock);
            cycles++;
        end
        checkOutput("flush busy before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        checkOutput("flush busy after", 64'(busy), 64'd0);
        checkOutput("flush no done", 64'(done), 64'd0);
        readHiLo(hi, lo);
        checkOutput("flush HI kept", 64'(hi), 64'h1234);
        checkOutput("flush LO kept", 64'(lo), 64'h5678);
        @(negedge clock);
        checkOutput("flush no late done", 64'(done), 64'd0);
        runCheck("MULTU 2x3", MULTU, 32'd2, 32'd3, 5, 32'h0, 32'h6);

        // Write request while busy is ignored; reads show old LO meanwhile.
        applyStimulus(MULTU, 32'd3, 32'd5);
        start     = 1'b1;
        operation = WRITE_LO;
        operand1  = 32'h55;
        #1 checkOutput("read old LO while busy", 64'(dataRead), 64'h6);
        @(negedge clock);
        start     = 1'b0;
        operation = READ_LO;
        waitDone(cycles, doneSeen);
        checkOutput("busy write remaining cycles", 64'(cycles), 64'd4);
        checkOutput("busy write done", 64'(doneSeen), 64'd1);
        readHiLo(hi, lo);
        checkOutput("busy write HI", 64'(hi), 64'h0);
        checkOutput("busy write LO", 64'(lo), 64'd15);

        // Reset at busy cycle 5 of a divide.
        writeReg(WRITE_HI, 32'h0000AAAA);
        writeReg(WRITE_LO, 32'h0000BBBB);
        applyStimulus(DIV, 32'd100, 32'd7);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("mid reset busy", 64'(busy), 64'd0);
        checkOutput("mid reset done", 64'(done), 64'd0);
        readHiLo(hi, lo);
        checkOutput("mid reset HI", 64'(hi), 64'd0);
        checkOutput("mid reset LO", 64'(lo), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("post reset done", 64'(done), 64'd0);

        // flush beats a same-cycle write and a same-cycle multiply.
        writeReg(WRITE_HI, 32'h00000011);
        @(negedge clock);
        start     = 1'b1;
        flush     = 1'b1;
        operation = WRITE_HI;
        operand1  = 32'h00000099;
        @(negedge clock);
        operation = MULT;
        @(negedge clock);
        start = 1'b0;
        flush = 1'b0;
        checkOutput("flush+start busy", 64'(busy), 64'd0);
        readHiLo(hi, lo);
        checkOutput("flush+write HI", 64'(hi), 64'h11);

        // Reserved code is a no-op.
        applyStimulus(RESV, 32'h1, 32'h1);
        checkOutput("reserved busy", 64'(busy), 64'd0);
        readHiLo(hi, lo);
        checkOutput("reserved HI", 64'(hi), 64'h11);

        // MSUB 1x2 from {HI,LO} = {0,1}.
        writeReg(WRITE_HI, 32'h0);
        writeReg(WRITE_LO, 32'h1);
`ifdef MDU_MADD_EN
        runCheck("MSUB 1x2", MSUB, 32'd1, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFF);
`else
        applyStimulus(MSUB, 32'd1, 32'd2);
        checkOutput("MSUB off busy", 64'(busy), 64'd0);
        checkOutput("MSUB off done", 64'(done), 64'd0);
        readHiLo(hi, lo);
        checkOutput("MSUB off HI", 64'(hi), 64'h0);
        checkOutput("MSUB off LO", 64'(lo), 64'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multi_cycle_mdu.md
MULTI_CYCLE_MDU -- requirements
Module: multi_cycle_mdu

Interface
REQ-001 Parameter DATA_W, default 32: operand and HI/LO register width; legal values 8..64, even.
REQ-002 Parameter MUL_LAT, default 5: multiply busy cycles; legal values 1..16.
REQ-003 Parameter DIV_LAT: fixed at DATA_W; divide busy cycles, one quotient bit per cycle.
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  reset is synchronous and active-high.
REQ-006 start  in  1  request strobe; sampled only while busy=0.
REQ-007 flush  in  1  abort the in-flight operation.
REQ-008 operation  in  4  0 READ_HI, 1 READ_LO, 2 WRITE_HI, 3 WRITE_LO, 4 MULT, 5 MULTU, 6 DIV, 7 DIVU, 8 MADD, 9 MADDU, 10 MSUB, 11 MSUBU; 12-15 reserved.
REQ-009 operand1  in  DATA_W  rs value: dividend, multiplicand, or HI/LO write data.
REQ-010 operand2  in  DATA_W  rt value: divisor or multiplier.
REQ-011 busy  out  1  long operation in flight.
REQ-012 done  out  1  one-cycle pulse on the cycle HI/LO take a long-operation result.
REQ-013 dataRead  out  DATA_W  HI when operation=READ_HI, otherwise LO; combinational.

Function
REQ-014 FSM states: IDLE, MUL, DIV; state is IDLE whenever busy=0.
REQ-015 IDLE with start=1, flush=0 and operation 4/5 (or 8-11 when enabled): latch the operands, load a counter with MUL_LAT, go to MUL, and assert busy from the next cycle.
REQ-016 IDLE with start=1, flush=0 and operation 6/7: latch the operands, load the counter with DATA_W, go to DIV, and assert busy from the next cycle.
REQ-017 IDLE with start=1 and operation WRITE_HI/WRITE_LO: HI/LO take operand1 at that edge; busy stays 0; no done pulse.
REQ-018 READ_HI/READ_LO and reserved codes with start=1: no state change.
REQ-019 MUL: full 2*DATA_W product, signed for MULT and unsigned for MULTU; result is {HI,LO}.
REQ-020 DIV: restoring iterative divide, one bit per cycle; LO=quotient, HI=remainder; the signed remainder takes the sign of the dividend, and the quotient truncates toward zero.
REQ-021 The counter decrements each cycle in MUL/DIV; at the edge it reaches zero, HI/LO load, state returns to IDLE, busy falls, and done=1 for the following cycle.
REQ-022 Total busy cycles: exactly MUL_LAT for multiply and DATA_W for divide.
REQ-023 Divisor zero: HI=dividend, LO=all ones after the normal DIV_LAT; no exception.
REQ-024 DIV with dividend = signed minimum and divisor = -1: LO = signed minimum, HI=0.
REQ-025 While busy, start is ignored and dataRead returns the old HI/LO.
REQ-026 flush=1 while busy: the operation is discarded, HI/LO are unchanged, state goes to IDLE at that edge, and there is no done pulse.
REQ-027 flush=1 together with start=1 in IDLE: flush wins; the request is dropped, including WRITE_HI/WRITE_LO.
REQ-028 Operands are sampled only at acceptance; later input changes do not affect the result.

Reset
REQ-029 reset=1 at a rising edge: HI=0, LO=0, state IDLE, counter=0, busy=0, done=0; any in-flight operation is abandoned.
REQ-030 reset has priority over flush and start in the same cycle.

Configuration
REQ-031 Macro MDU_MADD_EN defined: operations 8-11 accumulate as {HI,LO} = {HI,LO} ± product, signed for 8/10 and unsigned for 9/11, modulo 2^(2*DATA_W), with MUL_LAT timing.
REQ-032 Macro MDU_MADD_EN undefined: codes 8-11 are treated as reserved, per REQ-018.

Verification
REQ-033 DATA_W=32, MUL_LAT=5: MULT -3 × 7 -> busy high for 5 cycles, then done; HI=FFFFFFFF, LO=FFFFFFEB.
REQ-034 DIV -7 / 2 -> busy for 32 cycles; LO=FFFFFFFD, HI=FFFFFFFF. DIVU 7 / 0 -> HI=00000007, LO=FFFFFFFF.
REQ-035 DIVU started; flush at busy cycle 10 -> busy=0 next cycle, no done, and HI/LO keep their prior values; a new MULTU 2×3 is then accepted and gives LO=6.
REQ-036 MULTU running; start with WRITE_LO=0x55 mid-operation -> ignored, and the final LO is the product.
REQ-037 reset asserted during DIV at cycle 5 -> next cycle HI=LO=0, busy=0, done=0.
REQ-038 With MDU_MADD_EN: HI=0, LO=1, then MSUB 1×2 -> HI=FFFFFFFF, LO=FFFFFFFF; without MDU_MADD_EN, the same request leaves HI/LO unchanged and busy=0.
